// File: rtl/csa_out_collector_if.sv
// csa_out_collector_if
// Bundles the calc-array side (ready/strobe/result words) and the result
// stream side (valid/ready/data) of the CSA output collector.
//   master : collector view (drives csa_out_ren, m_valid, m_data[, m_src])
//   slave  : environment view (calc wraps + stream consumer)
// Optional: CSA_COLLECT_SRC_TAG_EN adds the 8-bit m_src head tag.
interface csa_out_collector_if #(
    parameter int unsigned CSA_CALC_INST_NUM        = 4,
    parameter int unsigned CSA_OUT_PARAMETER_LENGTH = 224
);
    localparam int unsigned N = CSA_CALC_INST_NUM;
    localparam int unsigned L = CSA_OUT_PARAMETER_LENGTH;

    logic [N-1:0]   csa_out_ready;
    logic [N-1:0]   csa_out_ren;
    logic [N*L-1:0] csa_out;
    logic           m_valid;
    logic           m_ready;
    logic [L-1:0]   m_data;
`ifdef CSA_COLLECT_SRC_TAG_EN
    logic [7:0]     m_src;
`endif

    modport master (
        input  csa_out_ready,
        input  csa_out,
        input  m_ready,
        output csa_out_ren,
        output m_valid,
        output m_data
`ifdef CSA_COLLECT_SRC_TAG_EN
        ,
        output m_src
`endif
    );

    modport slave (
        output csa_out_ready,
        output csa_out,
        output m_ready,
        input  csa_out_ren,
        input  m_valid,
        input  m_data
`ifdef CSA_COLLECT_SRC_TAG_EN
        ,
        input  m_src
`endif
    );
endinterface

// File: rtl/csa_out_collector.sv
// csa_out_collector
// Round-robin result collector: polls csa_out_ready of each calc wrap,
// strobes csa_out_ren for one cycle, captures the show-ahead csa_out word
// into a small FIFO and presents it as a valid/ready stream.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus (master)    : csa_out_ready/csa_out_ren/csa_out, m_valid/m_ready/m_data[/m_src]
//   fifo_count      : entries currently held
//   collected_count : results captured since reset (wraps)
// Optional: define CSA_COLLECT_SRC_TAG_EN to store the source index per
// entry and drive m_src.
module csa_out_collector #(
    parameter int unsigned AXI_DATA_WIDTH           = 32,
    parameter int unsigned CSA_CALC_INST_NUM        = 4,
    parameter int unsigned CSA_OUT_PARAMETER_LENGTH = AXI_DATA_WIDTH * 7,
    parameter int unsigned FIFO_DEPTH               = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    csa_out_collector_if.master       bus,
    output logic [AXI_DATA_WIDTH-1:0] fifo_count,
    output logic [AXI_DATA_WIDTH-1:0] collected_count
);
    localparam int unsigned L  = CSA_OUT_PARAMETER_LENGTH;
    localparam int unsigned N  = CSA_CALC_INST_NUM;
    localparam int unsigned AW = AXI_DATA_WIDTH;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned IW = 8;

    typedef enum logic {SCAN, READ} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d, idx_inc;
    logic [N-1:0]    ren_q, ren_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            valid_q, valid_d;
    logic [AW-1:0]   coll_q, coll_d;
    logic [L-1:0]    mem [FIFO_DEPTH];
`ifdef CSA_COLLECT_SRC_TAG_EN
    logic [IW-1:0]   mem_src [FIFO_DEPTH];
`endif

    logic            sel_ready;
    logic [L-1:0]    sel_data;
    logic            room;
    logic            push;
    logic            pop;

    // Select the polled instance's ready flag and result word.
    always_comb begin
        sel_ready = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (idx_q == IW'(i)) begin
                sel_ready = bus.csa_out_ready[i];
                sel_data  = bus.csa_out[i*L +: L];
            end
        end
    end

    // Next-state, strobe and FIFO bookkeeping.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ren_d    = '0;
        idx_inc  = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
        room     = (count_q < CW'(FIFO_DEPTH));
        push     = (state_q == READ);
        pop      = valid_q & bus.m_ready;

        case (state_q)
            SCAN: begin
                if (sel_ready && room) begin
                    ren_d   = N'(1) << idx_q;
                    state_d = READ;
                end else if (!sel_ready) begin
                    // A ready instance blocked only by a full FIFO keeps its turn.
                    idx_d = idx_inc;
                end
            end
            READ: begin
                // Always move on after a read so no instance is polled twice in a row.
                idx_d   = idx_inc;
                state_d = SCAN;
            end
            default: state_d = SCAN;
        endcase

        count_d  = count_q + CW'(push) - CW'(pop);
        valid_d  = (count_d != '0);
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        coll_d   = push ? coll_q + AW'(1)   : coll_q;
    end

    // State, control and FIFO storage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SCAN;
            idx_q    <= '0;
            ren_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            coll_q   <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
`ifdef CSA_COLLECT_SRC_TAG_EN
                mem_src[i] <= '0;
`endif
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ren_q    <= ren_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            coll_q   <= coll_d;
            // idx is held through READ, so sel_data is the strobed instance's word.
            if (push) begin
                mem[wr_ptr_q] <= sel_data;
`ifdef CSA_COLLECT_SRC_TAG_EN
                mem_src[wr_ptr_q] <= idx_q;
`endif
            end
        end
    end

    assign bus.csa_out_ren = ren_q;
    assign bus.m_valid     = valid_q;
    assign bus.m_data      = mem[rd_ptr_q];
`ifdef CSA_COLLECT_SRC_TAG_EN
    assign bus.m_src       = mem_src[rd_ptr_q];
`endif
    assign fifo_count      = AW'(count_q);
    assign collected_count = coll_q;

endmodule

// File: tb/tb_csa_out_collector.sv
// Directed bench for csa_out_collector with a show-ahead wrap model per instance.
module tb_csa_out_collector;
    localparam int unsigned N = 4;
    localparam int unsigned L = 224;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fifo_count;
    logic [31:0] collected_count;

    csa_out_collector_if #(.CSA_CALC_INST_NUM(N), .CSA_OUT_PARAMETER_LENGTH(L)) bus ();

    csa_out_collector #(
        .AXI_DATA_WIDTH(32),
        .CSA_CALC_INST_NUM(N),
        .CSA_OUT_PARAMETER_LENGTH(L),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .fifo_count(fifo_count),
        .collected_count(collected_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Wrap model: remaining results and current head block value per instance.
    int avail [N];
    int blk   [N];

    // Values sampled mid-cycle by step().
    logic [N-1:0] s_ren;
    logic         s_valid;
    logic         s_mready;
    logic [L-1:0] s_data;
    logic [31:0]  s_count;
    logic [31:0]  s_coll;

    int           strobe_cyc [$];
    int           strobe_inst [$];
    logic [L-1:0] rx_q [$];
    logic [7:0]   rx_src [$];

    function automatic logic [L-1:0] make_word(input int inst, input int b);
        logic [L-1:0] w;
        w = '0;
        w[31:0]      = 32'(b);
        w[63:32]     = 32'(inst);
        w[L-1 -: 32] = 32'hC5A0_0000 | 32'(inst);
        return w;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < int'(N); i++) begin
            bus.csa_out_ready[i]   = (avail[i] > 0);
            bus.csa_out[i*L +: L]  = make_word(i, blk[i]);
        end
    endtask

    // One clock: sample at negedge, then advance the wrap model after the edge.
    task automatic step();
        @(negedge clk);
        s_ren    = bus.csa_out_ren;
        s_valid  = bus.m_valid;
        s_mready = bus.m_ready;
        s_data   = bus.m_data;
        s_count  = fifo_count;
        s_coll   = collected_count;
        if (s_valid === 1'b1 && s_mready === 1'b1) begin
            rx_q.push_back(s_data);
`ifdef CSA_COLLECT_SRC_TAG_EN
            rx_src.push_back(bus.m_src);
`endif
        end
        for (int i = 0; i < int'(N); i++) begin
            if (s_ren[i] === 1'b1) begin
                strobe_cyc.push_back(cyc);
                strobe_inst.push_back(i);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(N); i++) begin
            if (s_ren[i] === 1'b1 && avail[i] > 0) begin
                avail[i]--;
                blk[i]++;
            end
        end
        drive_inputs();
        cyc++;
    endtask

    task automatic reset_assert();
        rst = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            avail[i] = 0;
            blk[i]   = 1;
        end
        drive_inputs();
        step();
        step();
    endtask

    task automatic reset_release();
        drive_inputs();
        rst = 1'b0;
        strobe_cyc.delete();
        strobe_inst.delete();
        rx_q.delete();
        rx_src.delete();
        cyc = 0;
    endtask

    task automatic test_reset();
        bus.m_ready = 1'b0;
        reset_assert();
        checks++; if (s_ren !== '0)    begin errors++; $display("FAIL reset_ren got %b expected 0000", s_ren); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", s_valid); end
        checks++; if (s_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", s_count); end
        checks++; if (s_coll !== 32'd0) begin errors++; $display("FAIL reset_collected got %0d expected 0", s_coll); end
        checks++; if (s_data !== '0)    begin errors++; $display("FAIL reset_data got %h expected 0", s_data); end
`ifdef CSA_COLLECT_SRC_TAG_EN
        checks++; if (bus.m_src !== 8'd0) begin errors++; $display("FAIL reset_src got %0d expected 0", bus.m_src); end
`endif
    endtask

    task automatic test_single();
        reset_assert();
        avail[2] = 1;
        blk[2]   = 1;
        bus.m_ready = 1'b1;
        reset_release();
        repeat (4) step();
        checks++; if (s_ren !== 4'b0100) begin errors++; $display("FAIL single_ren_c3 got %b expected 0100", s_ren); end
        step();
        checks++; if (s_ren !== 4'b0000) begin errors++; $display("FAIL single_ren_c4 got %b expected 0000", s_ren); end
        checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b expected 1", s_valid); end
        checks++; if (s_data !== make_word(2, 1)) begin errors++; $display("FAIL single_data got %h expected %h", s_data, make_word(2, 1)); end
        checks++; if (s_coll !== 32'd1) begin errors++; $display("FAIL single_collected got %0d expected 1", s_coll); end
        repeat (3) step();
        checks++; if (strobe_cyc.size() != 1) begin errors++; $display("FAIL single_strobes got %0d expected 1", strobe_cyc.size()); end
        checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL single_rx got %0d expected 1", rx_q.size()); end
        checks++; if (s_count !== 32'd0) begin errors++; $display("FAIL single_count got %0d expected 0", s_count); end
`ifdef CSA_COLLECT_SRC_TAG_EN
        checks++;
        if (rx_src.size() != 1 || rx_src[0] !== 8'd2) begin
            errors++; $display("FAIL single_src got %0d expected 2", (rx_src.size() > 0) ? int'(rx_src[0]) : -1);
        end
`endif
    endtask

    task automatic test_back_to_back();
        reset_assert();
        for (int i = 0; i < int'(N); i++) avail[i] = 3;
        bus.m_ready = 1'b1;
        reset_release();
        repeat (30) step();
        checks++; if (strobe_cyc.size() != 12) begin errors++; $display("FAIL rr_strobes got %0d expected 12", strobe_cyc.size()); end
        for (int k = 0; k < 12; k++) begin
            if (k < strobe_cyc.size()) begin
                checks++;
                if (strobe_cyc[k] != 1 + 2*k || strobe_inst[k] != k % 4) begin
                    errors++;
                    $display("FAIL rr_strobe%0d got cyc %0d inst %0d expected cyc %0d inst %0d",
                             k, strobe_cyc[k], strobe_inst[k], 1 + 2*k, k % 4);
                end
            end
            if (k < rx_q.size()) begin
                checks++;
                if (rx_q[k] !== make_word(k % 4, k / 4 + 1)) begin
                    errors++; $display("FAIL rr_data%0d got %h expected %h", k, rx_q[k], make_word(k % 4, k / 4 + 1));
                end
            end
        end
        checks++; if (rx_q.size() != 12) begin errors++; $display("FAIL rr_rx got %0d expected 12", rx_q.size()); end
        checks++; if (s_coll !== 32'd12) begin errors++; $display("FAIL rr_collected got %0d expected 12", s_coll); end
    endtask

    task automatic test_backpressure();
        int pcyc;
        reset_assert();
        for (int i = 0; i < int'(N); i++) avail[i] = 3;
        bus.m_ready = 1'b0;
        reset_release();
        repeat (16) step();
        checks++; if (strobe_cyc.size() != 4) begin errors++; $display("FAIL bp_strobes got %0d expected 4", strobe_cyc.size()); end
        checks++; if (s_count !== 32'd4) begin errors++; $display("FAIL bp_count got %0d expected 4", s_count); end
        checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b expected 1", s_valid); end
        bus.m_ready = 1'b1;
        step();
        pcyc = cyc - 1;
        bus.m_ready = 1'b0;
        repeat (10) step();
        checks++; if (strobe_cyc.size() != 5) begin errors++; $display("FAIL bp_strobes_after got %0d expected 5", strobe_cyc.size()); end
        if (strobe_cyc.size() >= 5) begin
            checks++;
            if (strobe_cyc[4] != pcyc + 2 || strobe_inst[4] != 0) begin
                errors++; $display("FAIL bp_resume got cyc %0d inst %0d expected cyc %0d inst 0",
                                   strobe_cyc[4], strobe_inst[4], pcyc + 2);
            end
        end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== make_word(0, 1)) begin
            errors++; $display("FAIL bp_pop got %0d entries expected 1 entry of inst 0 block 1", rx_q.size());
        end
        checks++; if (s_count !== 32'd4) begin errors++; $display("FAIL bp_count_refill got %0d expected 4", s_count); end
    endtask

    task automatic test_push_pop();
        reset_assert();
        for (int i = 0; i < int'(N); i++) avail[i] = 3;
        bus.m_ready = 1'b0;
        reset_release();
        repeat (7) step();
        checks++; if (s_count !== 32'd3) begin errors++; $display("FAIL pp_count_c6 got %0d expected 3", s_count); end
        bus.m_ready = 1'b1;
        step();
        checks++; if (s_ren !== 4'b1000) begin errors++; $display("FAIL pp_ren_c7 got %b expected 1000", s_ren); end
        bus.m_ready = 1'b0;
        step();
        checks++; if (s_count !== 32'd3) begin errors++; $display("FAIL pp_count_c8 got %0d expected 3", s_count); end
        bus.m_ready = 1'b1;
        repeat (20) step();
        checks++; if (rx_q.size() < 8) begin errors++; $display("FAIL pp_rx got %0d expected at least 8", rx_q.size()); end
        for (int k = 0; k < 8 && k < rx_q.size(); k++) begin
            checks++;
            if (rx_q[k] !== make_word(k % 4, k / 4 + 1)) begin
                errors++; $display("FAIL pp_order%0d got %h expected %h", k, rx_q[k], make_word(k % 4, k / 4 + 1));
            end
        end
    endtask

    task automatic test_reset_in_read();
        reset_assert();
        for (int i = 0; i < int'(N); i++) avail[i] = 3;
        bus.m_ready = 1'b1;
        reset_release();
        step();
        rst = 1'b1;
        step();
        checks++; if (s_ren !== 4'b0001) begin errors++; $display("FAIL rir_ren_read got %b expected 0001", s_ren); end
        rst = 1'b0;
        step();
        checks++; if (s_ren !== 4'b0000) begin errors++; $display("FAIL rir_ren_drop got %b expected 0000", s_ren); end
        checks++; if (s_count !== 32'd0) begin errors++; $display("FAIL rir_count got %0d expected 0", s_count); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rir_valid got %b expected 0", s_valid); end
        checks++; if (s_coll !== 32'd0) begin errors++; $display("FAIL rir_collected got %0d expected 0", s_coll); end
        step();
        checks++; if (s_ren !== 4'b0001) begin errors++; $display("FAIL rir_restart got %b expected 0001", s_ren); end
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL rir_rx got %0d expected 0", rx_q.size()); end
    endtask

    task automatic test_wrap_model();
        int exp_b [8] = '{1, 4, 6, 7, 2, 5, 8, 3};
        int exp_i [8] = '{0, 1, 2, 3, 0, 1, 3, 0};
        reset_assert();
        avail[0] = 3; blk[0] = 1;
        avail[1] = 2; blk[1] = 4;
        avail[2] = 1; blk[2] = 6;
        avail[3] = 2; blk[3] = 7;
        bus.m_ready = 1'b1;
        reset_release();
        repeat (30) step();
        checks++; if (rx_q.size() != 8) begin errors++; $display("FAIL wm_rx got %0d expected 8", rx_q.size()); end
        for (int k = 0; k < 8 && k < rx_q.size(); k++) begin
            checks++;
            if (rx_q[k] !== make_word(exp_i[k], exp_b[k])) begin
                errors++; $display("FAIL wm_seq%0d got %h expected %h", k, rx_q[k], make_word(exp_i[k], exp_b[k]));
            end
`ifdef CSA_COLLECT_SRC_TAG_EN
            if (k < rx_src.size()) begin
                checks++;
                if (rx_src[k] !== 8'(exp_i[k])) begin
                    errors++; $display("FAIL wm_src%0d got %0d expected %0d", k, rx_src[k], exp_i[k]);
                end
            end
`endif
        end
        checks++; if (s_coll !== 32'd8) begin errors++; $display("FAIL wm_collected got %0d expected 8", s_coll); end
    endtask

    initial begin
        rst = 1'b1;
        bus.m_ready = 1'b0;
        bus.csa_out_ready = '0;
        bus.csa_out = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_push_pop();
        test_reset_in_read();
        test_wrap_model();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/csa_out_collector.md
# csa_out_collector

Round-robin result collector for the CSA calculation array. It polls the `csa_out_ready` flags of `CSA_CALC_INST_NUM` `csa_calc_logic_wrap` instances and pulses the matching `csa_out_ren`. It captures the selected `csa_out` word into an internal FIFO and presents the results as a single valid/ready stream toward the AXI register side. It is the read-side counterpart of the input dispatcher; the output layout matches the wrap's `csa_out` packing: block, in, times, times_start, out.

## Interface
- `AXI_DATA_WIDTH`, 32, word width.
- `CSA_CALC_INST_NUM`, 4, number of calc instances polled (1..255).
- `CSA_OUT_PARAMETER_LENGTH`, `AXI_DATA_WIDTH*7`, width of one result word.
- `FIFO_DEPTH`, 4, result FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `csa_out_ready`  in  `CSA_CALC_INST_NUM`  per-instance result available.
- `csa_out_ren`  out  `CSA_CALC_INST_NUM`  per-instance read strobe; one-hot or zero, registered.
- `csa_out`  in  `CSA_CALC_INST_NUM*CSA_OUT_PARAMETER_LENGTH`  flattened results; instance i at bits `[(i+1)*L-1 : i*L]`.
- `m_valid`  out  1  FIFO non-empty.
- `m_ready`  in  1  consumer accepts head.
- `m_data`  out  `CSA_OUT_PARAMETER_LENGTH`  FIFO head.
- `m_src`  out  8  source instance of head (only with `CSA_COLLECT_SRC_TAG_EN`).
- `fifo_count`  out  `AXI_DATA_WIDTH`  entries held.
- `collected_count`  out  `AXI_DATA_WIDTH`  total results captured since reset; wraps at 2^32.

## Operation
- The wrap's output FIFO is show-ahead: `csa_out[i]` is valid during the cycle `csa_out_ren[i]` is high and advances after it.
- State `SCAN`:
  - If `csa_out_ready[idx]==1` and `fifo_count < FIFO_DEPTH`: register `csa_out_ren <= 1<<idx` and go to `READ`.
  - Otherwise advance `idx` (wrap from `CSA_CALC_INST_NUM-1` to 0) and stay in `SCAN`.
  - If the FIFO is full and `idx` is ready: hold `idx`, no strobe.
- State `READ`:
  - `csa_out_ren` is high for exactly this cycle.
  - At the closing edge, write `csa_out[idx]` (and `idx` as tag) to the FIFO and increment `collected_count`.
  - Clear `csa_out_ren`, advance `idx`, return to `SCAN`.
  - The collector does not re-poll the same instance back to back, which guarantees fairness.
- At most one read is outstanding; the room check in `SCAN` guarantees the `READ` write never overflows.
- Pop: on `m_valid && m_ready`, advance the read pointer.
- Simultaneous push and pop: `fifo_count` is unchanged and both pointers move.
- Pointers are `log2(FIFO_DEPTH)` bits and wrap naturally.
- Reset, all outputs: `csa_out_ren=0`, `m_valid=0`, `m_data` don't-care (0 preferred), `m_src=0`, `fifo_count=0`, `collected_count=0`.
- Reset, internal state: `idx=0`, state `SCAN`.
- Reset in `READ`: the strobe drops next cycle, the in-flight result is discarded, and the FIFO is emptied.

## Timing
- `csa_out_ready[i]` first sampled high in `SCAN` at cycle c0 with `idx==i` → `csa_out_ren[i]=1` in c1 → entry written at end of c1 → `m_valid=1` in c2.
- Minimum spacing between strobes is 2 cycles; peak throughput is one result per 2 cycles.
- Scan latency to reach instance i from `idx` is `(i-idx) mod N` cycles.
- `m_data`/`m_valid` are driven from registers; there is no combinational path from `csa_out` or `m_ready` to outputs except the FIFO head mux.

## Configuration
- `CSA_COLLECT_SRC_TAG_EN` defined:
  - each FIFO entry also stores the 8-bit source index;
  - `m_src` port exists and follows the head entry.
- Undefined: no tag storage and no `m_src` port; all other behaviour is identical.

## Test plan
- Only instance 2 ready from reset release, `m_ready=1` → `csa_out_ren=4'b0100` for one cycle exactly 3 cycles after reset release (scan 0,1,2); `m_data` equals instance 2 word with block=1; `m_src=2`; `collected_count=1`.
- All four ready continuously, `m_ready=1` → strobes in order 0,1,2,3,0… every 2 cycles; `collected_count` increments every 2 cycles.
- `m_ready=0`, all ready → exactly 4 strobes; `fifo_count=4`; no further strobe. Raise `m_ready` for one cycle → next strobe no earlier than the cycle after the pop.
- FIFO at 3 entries, `m_ready=1` while a `READ` writes → `fifo_count` stays 3; data emerges in capture order.
- Assert `rst` during a `READ` cycle → `csa_out_ren=0` next cycle; `fifo_count=0`; `m_valid=0`; scanning restarts at `idx=0`.
- Wrap model returns block values 1..8 across 4 instances → collected sequence matches per-instance FIFO order; no loss or duplication.
